// File: rtl/game_pkg.sv
// game_pkg: shared geometry, phase/FSM types and score helper for the paddle game
package game_pkg;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int PAD_H     = 64;
  localparam int PAD_W     = 8;
  localparam int PAD_X1    = 16;
  localparam int PAD_X2    = 616;
  localparam int BALL_SZ   = 8;
  localparam int BALL_SPD  = 4;
  localparam int PAD_SPD   = 6;
  localparam int DEADZONE  = 32;
  localparam int WIN_SCORE = 7;
  localparam int STICK_MID = 128;
  localparam logic [9:0] PAD_Y0    = 10'((SCREEN_H - PAD_H) / 2);
  localparam logic [9:0] BALL_X0   = 10'((SCREEN_W - BALL_SZ) / 2);
  localparam logic [9:0] BALL_Y0   = 10'((SCREEN_H - BALL_SZ) / 2);
  localparam logic [9:0] BALL_STEP = 10'(BALL_SPD);
  localparam logic [9:0] BALL_SIDE = 10'(BALL_SZ);
  localparam logic [9:0] PAD_HT    = 10'(PAD_H);
  localparam logic [9:0] Y_BOT     = 10'(SCREEN_H - BALL_SZ);
  localparam logic [9:0] X_HIT_L   = 10'(PAD_X1 + PAD_W);
  localparam logic [9:0] X_EDGE_L  = 10'(PAD_X1 - BALL_SZ);
  localparam logic [9:0] X_HIT_R   = 10'(PAD_X2 - BALL_SZ);
  localparam logic [9:0] X_EDGE_R  = 10'(PAD_X2 + PAD_W);
  localparam logic [9:0] X_MISS_R  = 10'(SCREEN_W - BALL_SZ);
  localparam logic signed [10:0] PAD_STEP  = 11'(PAD_SPD);
  localparam logic signed [10:0] PAD_Y_MAX = 11'(SCREEN_H - PAD_H);
  localparam logic [7:0] STICK_HI  = 8'(STICK_MID + DEADZONE);
  localparam logic [7:0] STICK_LO  = 8'(STICK_MID - DEADZONE);
  localparam logic [7:0] STICK_CTR = 8'(STICK_MID);
  localparam logic [3:0] WIN_PTS   = 4'(WIN_SCORE);
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, OVER = 2'd2} phase_t;
  typedef enum logic [2:0] {WAIT, PAD, BALL, HIT, COMMIT} fsm_t;
  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return s >= WIN_PTS ? WIN_PTS : s + 4'd1;
  endfunction
endpackage

// File: rtl/paddle_mover.sv
// paddle_mover: stick deadzone decode and clamped one-frame paddle step
module paddle_mover
  import game_pkg::*;
(
  input  logic [9:0] y,
  input  logic [7:0] stick,
  output logic [9:0] y_next
);
  logic signed [10:0] up, dn;
  assign up = $signed({1'b0, y}) - PAD_STEP;
  assign dn = $signed({1'b0, y}) + PAD_STEP;
  assign y_next = stick > STICK_HI ? (up < 11'sd0 ? 10'd0 : up[9:0]) :
                  stick < STICK_LO ? (dn > PAD_Y_MAX ? 10'(PAD_Y_MAX) : dn[9:0]) : y;
endmodule

// File: rtl/game_state_updater.sv
// game_state_updater: per-frame paddle/ball/score sequencer with atomic output commit
module game_state_updater
  import game_pkg::*;
(
  input  logic       clkin,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [7:0] stick_Y1,
  input  logic [7:0] stick_Y2,
  input  logic       z1,
  input  logic       z2,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] phase,
  output logic       frame_done
);
  fsm_t state, state_nxt;
  phase_t w_ph, h_ph;
  logic [7:0] snap_y1, snap_y2;
  logic snap_z1, snap_z2;
  logic [9:0] w_p1, w_p2, w_bx, w_by, p1_nxt, p2_nxt, b_bx, b_by, h_bx, h_by;
  logic w_dx, w_dy, b_dy, h_dx, h_dy, top_hit, bot_hit;
  logic [3:0] w_s1, w_s2, h_s1, h_s2;
  logic hit_l, hit_r, miss_l, miss_r;
  paddle_mover u_pad1 (.y(w_p1), .stick(snap_y1), .y_next(p1_nxt));
  paddle_mover u_pad2 (.y(w_p2), .stick(snap_y2), .y_next(p2_nxt));
  always_ff @(posedge clkin) state <= !rst ? WAIT : state_nxt;
  always_comb state_nxt = state == WAIT ? (frame_tick ? PAD : WAIT) :
                          state == PAD  ? BALL :
                          state == BALL ? HIT :
                          state == HIT  ? COMMIT : WAIT;
  // dx/dy: 1 = increasing coordinate
  assign top_hit = w_by < BALL_STEP;
  assign bot_hit = w_by > Y_BOT - BALL_STEP;
  assign b_bx = w_dx ? w_bx + BALL_STEP : w_bx - BALL_STEP;
  assign b_by = w_dy ? (bot_hit ? Y_BOT : w_by + BALL_STEP) : (top_hit ? 10'd0 : w_by - BALL_STEP);
  assign b_dy = w_dy ? !bot_hit : top_hit;
  assign hit_l = !w_dx && w_bx <= X_HIT_L && w_bx > X_EDGE_L &&
                 w_by + BALL_SIDE > w_p1 && w_by < w_p1 + PAD_HT;
  assign hit_r = w_dx && w_bx >= X_HIT_R && w_bx < X_EDGE_R &&
                 w_by + BALL_SIDE > w_p2 && w_by < w_p2 + PAD_HT;
  assign miss_l = w_bx == 10'd0;
  assign miss_r = w_bx >= X_MISS_R;
  always_comb begin
    h_bx = w_bx;
    h_by = w_by;
    h_dx = w_dx;
    h_dy = w_dy;
    h_s1 = w_s1;
    h_s2 = w_s2;
    h_ph = w_ph;
    if (w_ph == PLAY) begin
      if (hit_l) begin
        h_bx = X_HIT_L;
        h_dx = 1'b1;
      end else if (hit_r) begin
        h_bx = X_HIT_R;
        h_dx = 1'b0;
      end else if (miss_l || miss_r) begin
        h_s1 = miss_r ? score_inc(w_s1) : w_s1;
        h_s2 = miss_l ? score_inc(w_s2) : w_s2;
        h_bx = BALL_X0;
        h_by = BALL_Y0;
        h_dx = miss_r;
        h_ph = (miss_l ? score_inc(w_s2) : score_inc(w_s1)) == WIN_PTS ? OVER : SERVE;
      end
    end else if (w_ph == SERVE) begin
      h_ph = (snap_z1 || snap_z2) ? PLAY : SERVE;
    end else if (snap_z1 && snap_z2) begin
      h_s1 = 4'd0;
      h_s2 = 4'd0;
      h_bx = BALL_X0;
      h_by = BALL_Y0;
      h_dx = 1'b1;
      h_dy = 1'b1;
      h_ph = SERVE;
    end
  end
  always_ff @(posedge clkin) begin
    if (!rst) begin
      {snap_y1, snap_y2, snap_z1, snap_z2} <= {STICK_CTR, STICK_CTR, 2'b00};
      {w_p1, w_p2, w_bx, w_by} <= {PAD_Y0, PAD_Y0, BALL_X0, BALL_Y0};
      {w_dx, w_dy, w_s1, w_s2} <= {2'b11, 8'd0};
      w_ph <= SERVE;
      {paddle1_y, paddle2_y, ball_x, ball_y} <= {PAD_Y0, PAD_Y0, BALL_X0, BALL_Y0};
      {score1, score2, phase} <= {8'd0, SERVE};
      frame_done <= 1'b0;
    end else begin
      frame_done <= state == COMMIT;
      if (state == WAIT && frame_tick) {snap_y1, snap_y2, snap_z1, snap_z2} <= {stick_Y1, stick_Y2, z1, z2};
      if (state == PAD) {w_p1, w_p2} <= {p1_nxt, p2_nxt};
      if (state == BALL && w_ph == PLAY) {w_bx, w_by, w_dy} <= {b_bx, b_by, b_dy};
      if (state == HIT) begin
        {w_bx, w_by, w_dx, w_dy, w_s1, w_s2} <= {h_bx, h_by, h_dx, h_dy, h_s1, h_s2};
        w_ph <= h_ph;
      end
      if (state == COMMIT) begin
        {paddle1_y, paddle2_y, ball_x, ball_y} <= {w_p1, w_p2, w_bx, w_by};
        {score1, score2, phase} <= {w_s1, w_s2, w_ph};
      end
    end
  end
endmodule
